// File: rtl/add_driver_pkg.sv
// add_driver_pkg: shared constants and state encoding for the add/sub unit driver.
package add_driver_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
endpackage

// File: rtl/add_driver.sv
// add_driver: initiator for the external add/sub unit with running accumulator.
// Define ADD_DRIVER_CHECK_EN to add an internal result checker driving rsp_err.
module add_driver
    import add_driver_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_op,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);
    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] acc;
    logic             capture;

    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign capture   = state == ISSUE && cnt == '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    alu_a   <= cmd_acc ? acc : cmd_a;
                    alu_b   <= cmd_b;
                    alu_sel <= cmd_op;
                    cnt     <= 4'(SETTLE - 1);
                    state   <= ISSUE;
                end
                ISSUE: if (capture) begin
                    rsp_data <= alu_out;
                    acc      <= alu_out;
                    rsp_zero <= alu_out == '0;
                    state    <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_DRIVER_CHECK_EN
    logic [WIDTH-1:0] expected;
    assign expected = alu_sel == OP_SUB ? alu_a - alu_b : alu_a + alu_b;
    always_ff @(posedge clock) begin
        if (!reset) rsp_err <= 1'b0;
        else if (capture) rsp_err <= expected != alu_out;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_add_driver.sv
// tb_add_driver: table, directed and random checks of add_driver against a behavioural unit model.
module tb_add_driver;
`ifdef ADD_DRIVER_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;
    logic fault;

    logic       cmd_valid, cmd_ready, cmd_op, cmd_acc, alu_sel, rsp_valid, rsp_ready, rsp_zero, rsp_err, busy;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data;
    logic       s3_valid, s3_ready, s3_op, s3_acc, s3_sel, s3_rsp_valid, s3_rsp_ready, s3_zero, s3_err, s3_busy;
    logic [3:0] s3_a, s3_b, s3_alu_a, s3_alu_b, s3_alu_out, s3_data;

    function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b, input logic op);
        return op ? a - b : a + b;
    endfunction

    assign alu_out    = model(alu_a, alu_b, alu_sel) + {3'b0, fault};
    assign s3_alu_out = model(s3_alu_a, s3_alu_b, s3_sel);

    add_driver u1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    add_driver #(.WIDTH(4), .SETTLE(3)) u3 (
        .clock(clock), .reset(reset), .cmd_valid(s3_valid), .cmd_ready(s3_ready),
        .cmd_a(s3_a), .cmd_b(s3_b), .cmd_op(s3_op), .cmd_acc(s3_acc),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_sel(s3_sel), .alu_out(s3_alu_out),
        .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_data(s3_data),
        .rsp_zero(s3_zero), .rsp_err(s3_err), .busy(s3_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] acc_m = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full transaction on u1: accept, wait for response, optional back-pressure, handshake.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic op, input logic acc,
                          input int stall, input logic [3:0] exp_d, input logic exp_z, input string nm);
        logic [3:0] ea;
        int n;
        ea = acc ? acc_m : a;
        @(negedge clock);
        chk({nm, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_acc = acc;
        rsp_ready = stall == 0;
        @(negedge clock);
        cmd_valid = 1'b0; cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd1);
        chk({nm, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
        chk({nm, " rsp_zero"}, 32'(rsp_zero), 32'(exp_z));
        chk({nm, " rsp_err"}, 32'(rsp_err), 32'(CHK & fault));
        chk({nm, " alu_a"}, 32'(alu_a), 32'(ea));
        chk({nm, " alu_b"}, 32'(alu_b), 32'(b));
        chk({nm, " alu_sel"}, 32'(alu_sel), 32'(op));
        chk({nm, " cmd_ready resp"}, 32'(cmd_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk({nm, " stall valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, " stall data"}, 32'(rsp_data), 32'(exp_d));
            chk({nm, " stall cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk({nm, " after hs valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, " after hs busy"}, 32'(busy), 32'd0);
        chk({nm, " after hs alu_a held"}, 32'(alu_a), 32'(ea));
        rsp_ready = 1'b0;
        acc_m = exp_d;
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       op, acc;
        int         stall;
        logic [3:0] exp_d;
        logic       exp_z;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [3:0] ra, rb, ea, e;
        logic       rop, racc, held_ok;
        int         n;
        tbl[0] = '{4'd3,  4'd5, 1'b0, 1'b0, 0, 4'h8, 1'b0};
        tbl[1] = '{4'd2,  4'd5, 1'b1, 1'b0, 0, 4'hD, 1'b0};
        tbl[2] = '{4'd9,  4'd3, 1'b0, 1'b1, 0, 4'h0, 1'b1};
        tbl[3] = '{4'd15, 4'd1, 1'b0, 1'b0, 4, 4'h0, 1'b1};
        tbl[4] = '{4'd0,  4'd0, 1'b1, 1'b0, 0, 4'h0, 1'b1};
        tbl[5] = '{4'd0,  4'd1, 1'b1, 1'b0, 1, 4'hF, 1'b0};
        tbl[6] = '{4'd4,  4'd1, 1'b0, 1'b1, 2, 4'h0, 1'b1};

        fault = 1'b0; reset = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 1'b0; cmd_acc = 1'b0; rsp_ready = 1'b0;
        s3_valid = 1'b0; s3_a = '0; s3_b = '0; s3_op = 1'b0; s3_acc = 1'b0; s3_rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset outputs", 32'({alu_a, alu_b, alu_sel, rsp_data, rsp_zero, rsp_err}), 32'd0);
        reset = 1'b1;

        foreach (tbl[i])
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].acc, tbl[i].stall, tbl[i].exp_d, tbl[i].exp_z,
                   $sformatf("vec%0d", i));

        // Reset while the operation is in ISSUE must abort it and clear the accumulator.
        @(negedge clock);
        cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd3; cmd_op = 1'b0; cmd_acc = 1'b0; rsp_ready = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("midreset issue busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midreset outputs", 32'({alu_a, alu_b, alu_sel, rsp_data, rsp_zero, rsp_err, rsp_valid}), 32'd0);
        reset = 1'b1;
        acc_m = 4'd0;
        n = 0;
        repeat (3) begin
            @(negedge clock);
            n += int'(rsp_valid);
        end
        chk("midreset no response", 32'(n), 32'd0);
        rsp_ready = 1'b0;
        run_op(4'd11, 4'd4, 1'b0, 1'b1, 0, 4'd4, 1'b0, "acc after reset");

        // Faulty unit: data follows the unit, error flag only with the checker built in.
        fault = 1'b1;
        run_op(4'd3, 4'd4, 1'b0, 1'b0, 0, 4'd8, 1'b0, "fault add");
        run_op(4'd9, 4'd2, 1'b1, 1'b0, 1, 4'd8, 1'b0, "fault sub");
        fault = 1'b0;
        run_op(4'd9, 4'd2, 1'b1, 1'b0, 0, 4'd7, 1'b0, "fault cleared");

        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            rop = 1'($urandom); racc = 1'($urandom);
            ea = racc ? acc_m : ra;
            e = rop ? ea - rb : ea + rb;
            run_op(ra, rb, rop, racc, int'($urandom_range(0, 2)), e, e == 4'd0, $sformatf("rnd%0d", i));
        end

        // SETTLE=3 instance: operands held three cycles, 7-2 captured.
        @(negedge clock);
        chk("s3 idle ready", 32'(s3_ready), 32'd1);
        s3_valid = 1'b1; s3_a = 4'd7; s3_b = 4'd2; s3_op = 1'b1; s3_acc = 1'b0; s3_rsp_ready = 1'b1;
        @(negedge clock);
        s3_valid = 1'b0; s3_a = 4'd0; s3_b = 4'd0;
        held_ok = 1'b1;
        n = 0;
        while (!s3_rsp_valid && n < 20) begin
            held_ok &= s3_alu_a == 4'd7 && s3_alu_b == 4'd2 && s3_sel && s3_busy && !s3_ready;
            @(negedge clock);
            n++;
        end
        chk("s3 latency", 32'(n), 32'd3);
        chk("s3 operands held", 32'(held_ok), 32'd1);
        chk("s3 rsp_data", 32'(s3_data), 32'd5);
        chk("s3 rsp_zero/err", 32'({s3_zero, s3_err}), 32'd0);
        @(negedge clock);
        chk("s3 after hs", 32'({s3_rsp_valid, s3_busy}), 32'd0);
        s3_rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_driver.md
Name: add_driver

Overview:
- Initiator side of the 4-bit add/sub unit interface (a, b, sel in; out back).
- Accepts operation commands over a valid/ready port and drives registered operands to the external add/sub unit.
- Captures the unit's result after a fixed settle time and returns it over a valid/ready response port.
- Keeps a running accumulator, so results can be chained as the next operand.

Parameters:
- WIDTH, 4, operand/result width; must match the add/sub unit.
- SETTLE, 1, cycles operands are held on the unit interface before capture; legal range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_a  in  WIDTH  operand a; ignored when cmd_acc=1.
- cmd_b  in  WIDTH  operand b.
- cmd_op  in  1  0 = add, 1 = subtract (a - b).
- cmd_acc  in  1  1 = use accumulator as operand a.
- alu_a  out  WIDTH  registered operand to unit a input.
- alu_b  out  WIDTH  registered operand to unit b input.
- alu_sel  out  1  registered op select to unit (0 add, 1 sub).
- alu_out  in  WIDTH  unit result (combinational from alu_a/alu_b/alu_sel).
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  checker mismatch; see Optional Feature.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset low at a clock edge):
  - state = IDLE; alu_a/alu_b/alu_sel/rsp_data/accumulator = 0.
  - rsp_valid/rsp_zero/rsp_err = 0; settle counter = 0.
  - Reset takes priority over everything; a reset mid-operation aborts it, with no response produced.
- FSM states IDLE, ISSUE, RESP:
  - IDLE:
    - cmd_ready = 1.
    - On cmd_valid: alu_a <= cmd_acc ? acc : cmd_a; alu_b <= cmd_b; alu_sel <= cmd_op; counter <= SETTLE-1; go to ISSUE.
  - ISSUE:
    - cmd_ready = 0; operands stable.
    - When counter == 0: rsp_data <= alu_out; acc <= alu_out; rsp_zero <= (alu_out == 0); go to RESP.
    - Otherwise decrement counter.
  - RESP:
    - rsp_valid = 1; rsp_data/rsp_zero stable until handshake.
    - On rsp_ready, go to IDLE.
- cmd_ready is low in RESP, so there is no response/command overlap. The next command is accepted no earlier than the cycle after the response handshake.
- Latency: command accepted at edge T gives rsp_valid high in cycle T+SETTLE+1. With SETTLE=1 this is 2 cycles; throughput is 1 op per 3 cycles minimum.
- alu_* outputs hold their last values after completion; they are not returned to zero.
- Arithmetic is modulo 2^WIDTH, done by the external unit. No carry/borrow is reported.
  - 15+1 -> 0.
  - 2-5 -> 0xD.
- The accumulator updates only on capture. cmd_acc with no prior op uses 0.

Optional Feature:
- Macro: ADD_DRIVER_CHECK_EN.
- When defined:
  - Driver computes expected = alu_sel ? alu_a - alu_b : alu_a + alu_b, mod 2^WIDTH.
  - At capture, rsp_err <= (expected != alu_out); valid with rsp_valid.
- When not defined: rsp_err is tied to 0 and no checker logic is present.

Decomposition:
- Package add_driver_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - State enum {IDLE, ISSUE, RESP}.
  - WIDTH default constant.
- Single module; no sub-module needed.
- The checker is a small guarded block inside add_driver.

Test Plan (WIDTH=4, SETTLE=1, behavioural add/sub model on alu_* ports):
- cmd a=3, b=5, op=add, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=8, rsp_zero=0, alu_sel=0.
- cmd a=2, b=5, op=sub -> rsp_data=0xD; then cmd_acc=1, b=3, op=add -> alu_a=0xD, rsp_data=0x0, rsp_zero=1.
- cmd a=15, b=1, add, with rsp_ready low for 4 cycles:
  - rsp_valid stays high and rsp_data=0 stays stable.
  - cmd_ready=0 throughout.
  - Handshake -> IDLE next cycle.
- Assert reset low during ISSUE -> next cycle all outputs 0 and state IDLE; no response appears; acc=0.
- SETTLE=3: cmd 7-2 -> operands held 3 cycles, rsp_data=5 at accept+4.
- With ADD_DRIVER_CHECK_EN, model returns a+b+1 -> rsp_err=1; correct model -> rsp_err=0; macro undefined -> rsp_err always 0.
